key_packet_sender: RTL

//  Parametrised successor to the key-exchange send FSM. Captures the public-key result from the

---
 rtl/key_packet_sender_if.sv | 38 +++
 rtl/key_packet_sender.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/key_packet_sender_if.sv
// key_packet_sender_if
//   Bus bundle between the key packet sender, the curve core and the packet
//   TX buffer/transmitter.
//   master : the sender (drives buffer writes, send request and status)
//   slave  : the environment (drives curve result, done level and rx header)
//   Signals:
//     curve_out              KEY_W   key from curve core
//     curve_done             1       curve core result-valid level
//     incoming_packet_header 16      header of the most recently received packet
//     record_we/addr/data            TX buffer write port
//     send_req               1       one-cycle transmit request
//     busy/done/fail         1       status
interface key_packet_sender_if #(
  parameter int unsigned KEY_W  = 256,
  parameter int unsigned WORD_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic [KEY_W-1:0]  curve_out;
  logic              curve_done;
  logic [15:0]       incoming_packet_header;
  logic              record_we;
  logic [ADDR_W-1:0] record_addr;
  logic [WORD_W-1:0] record_data;
  logic              send_req;
  logic              busy;
  logic              done;
  logic              fail;

  modport master (
    input  curve_out, curve_done, incoming_packet_header,
    output record_we, record_addr, record_data, send_req, busy, done, fail
  );

  modport slave (
    output curve_out, curve_done, incoming_packet_header,
    input  record_we, record_addr, record_data, send_req, busy, done, fail
  );
endinterface

// File: rtl/key_packet_sender.sv
// key_packet_sender
//   Captures the public key from the curve core on a rising edge of
//   curve_done, writes it MSW-first into the TX packet buffer (one word per
//   cycle), requests transmission and waits for the acknowledge header,
//   retransmitting on timeout up to MAX_RETRY times.
//   Ports:
//     clock  in  system clock, posedge
//     reset  in  synchronous, active-high
//     bus    key_packet_sender_if.master (curve inputs, buffer write port,
//            send_req, busy/done/fail status)
//   Optional feature: define SENDER_CHECKSUM_EN to append one extra word at
//   address NW holding the XOR of all key words (burst of NW+1 writes).
module key_packet_sender #(
  parameter int unsigned KEY_W     = 256,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [15:0] ACK_HDR   = 16'h0001,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned MAX_RETRY = 3
) (
  input logic                clock,
  input logic                reset,
  key_packet_sender_if.master bus
);
  localparam int unsigned NW = KEY_W / WORD_W;
`ifdef SENDER_CHECKSUM_EN
  localparam int unsigned LAST_IDX = NW;
`else
  localparam int unsigned LAST_IDX = NW - 1;
`endif
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, SEND, WAIT_ACK, DONE, FAIL
  } state_t;

  state_t            state, state_d;
  logic [KEY_W-1:0]  key_q;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [RTY_W-1:0]  retry;
  logic              curve_done_q;
  logic              armed;
  logic              start;
  logic              ack;
  logic              timeout;
  logic              can_retry;
  logic [WORD_W-1:0] cur_word;
`ifdef SENDER_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
`endif

  // armed stays low while curve_done is held high through reset, so a level
  // that was already high at reset release cannot masquerade as an edge.
  assign start     = bus.curve_done & ~curve_done_q & armed;
  assign ack       = (bus.incoming_packet_header == ACK_HDR);
  assign timeout   = (cnt == CNT_W'(TIMEOUT - 1));
  assign can_retry = (retry < RTY_W'(MAX_RETRY));
  // The key register shifts left once per write, so the word to emit is
  // always the top slice; the latched key is not needed after the burst.
  assign cur_word  = key_q[KEY_W-1 -: WORD_W];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d         = state;
    bus.record_we   = 1'b0;
    bus.record_addr = '0;
    bus.record_data = '0;
    bus.send_req    = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.fail        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = WRITE;
      end
      WRITE: begin
        bus.busy        = 1'b1;
        bus.record_we   = 1'b1;
        bus.record_addr = idx;
`ifdef SENDER_CHECKSUM_EN
        bus.record_data = (idx == ADDR_W'(NW)) ? csum : cur_word;
`else
        bus.record_data = cur_word;
`endif
        if (idx == ADDR_W'(LAST_IDX)) state_d = SEND;
      end
      SEND: begin
        bus.busy     = 1'b1;
        bus.send_req = 1'b1;
        state_d      = WAIT_ACK;
      end
      WAIT_ACK: begin
        bus.busy = 1'b1;
        if (ack)          state_d = DONE;
        else if (timeout) state_d = can_retry ? SEND : FAIL;
      end
      DONE: begin
        bus.done = 1'b1;
        if (!bus.curve_done) state_d = IDLE;
      end
      FAIL: begin
        bus.fail = 1'b1;
        if (!bus.curve_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q        <= '0;
      idx          <= '0;
      cnt          <= '0;
      retry        <= '0;
      curve_done_q <= 1'b0;
      armed        <= ~bus.curve_done;
`ifdef SENDER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      curve_done_q <= bus.curve_done;
      if (!bus.curve_done) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            key_q <= bus.curve_out;
            idx   <= '0;
            retry <= '0;
`ifdef SENDER_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        WRITE: begin
          key_q <= key_q << WORD_W;
          idx   <= idx + 1'b1;
`ifdef SENDER_CHECKSUM_EN
          csum  <= csum ^ cur_word;
`endif
        end
        SEND: cnt <= '0;
        WAIT_ACK: begin
          if (!ack) begin
            cnt <= cnt + 1'b1;
            if (timeout && can_retry) retry <= retry + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
